// File: rtl/sync_queue_two_bit_counter_if.sv
// Fetch-side bundle: FIFO handshake plus predictor lookup/update signals.
// The slave modport is the sync_queue_two_bit_counter block; master is the fetch/execute side.
interface sync_queue_two_bit_counter_if #(
    parameter int DATA_SIZE = 96,
    parameter int ADDR_SIZE = 32
);
    logic                 kill;
    logic                 wready;
    logic                 wready_next;
    logic                 wvalid;
    logic [DATA_SIZE-1:0] wdata;
    logic                 rready;
    logic                 rvalid;
    logic [DATA_SIZE-1:0] rdata;
    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] next_pc;
    logic                 upd_valid;
    logic [ADDR_SIZE-1:0] upd_pc;
    logic                 upd_taken;
    logic [ADDR_SIZE-1:0] upd_target;

    modport master (
        output kill, wvalid, wdata, rready, pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  wready, wready_next, rvalid, rdata, next_pc
    );

    modport slave (
        input  kill, wvalid, wdata, rready, pc, upd_valid, upd_pc, upd_taken, upd_target,
        output wready, wready_next, rvalid, rdata, next_pc
    );
endinterface

// File: rtl/sync_queue_two_bit_counter.sv
// First-word-fall-through fetch FIFO with kill, plus a two-bit-counter next-PC predictor.
// Define SYNC_QUEUE_TBC_TAG_EN to add per-entry PC tags so aliasing PCs stop sharing predictions.
module sync_queue_two_bit_counter #(
    parameter int DATA_SIZE  = 96,
    parameter int QUEUE_SIZE = 16,
    parameter int ADDR_SIZE  = 32,
    parameter int TABLE_LOG2 = 6
) (
    input logic                     clk,
    input logic                     rst,
    sync_queue_two_bit_counter_if.slave bus
);
    localparam int PTR_W   = $clog2(QUEUE_SIZE);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRIES = 1 << TABLE_LOG2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_SIZE);

    logic [DATA_SIZE-1:0] mem [QUEUE_SIZE];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 do_write;
    logic                 do_read;

    // Full-queue writes are dropped even when a read frees a slot in the same cycle.
    always_comb begin
        bus.wready      = (count < FULL_CNT);
        bus.rvalid      = (count != '0);
        do_write        = bus.wvalid && bus.wready;
        do_read         = bus.rready && bus.rvalid;
        count_next      = count + CNT_W'(do_write) - CNT_W'(do_read);
        bus.wready_next = bus.kill || (count_next < FULL_CNT);
        bus.rdata       = bus.rvalid ? mem[head] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.kill) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_write) tail <= tail + PTR_W'(1);
            if (do_read)  head <= head + PTR_W'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !bus.kill && do_write) mem[tail] <= bus.wdata;
    end

    logic [1:0]           ctr    [ENTRIES];
    logic [ADDR_SIZE-1:0] target [ENTRIES];
    logic [ENTRIES-1:0]   v;
    logic [TABLE_LOG2-1:0] idx;
    logic [TABLE_LOG2-1:0] uidx;
    logic                 predict_taken;
    logic [1:0]           upd_base;
    logic [1:0]           upd_ctr;
    logic                 unused_pc_bits;

`ifdef SYNC_QUEUE_TBC_TAG_EN
    localparam int TAG_W = ADDR_SIZE - TABLE_LOG2 - 2;
    logic [TAG_W-1:0] tag [ENTRIES];
    logic [TAG_W-1:0] pc_tag;
    logic [TAG_W-1:0] upd_tag;
`endif

    always_comb begin
        idx  = bus.pc[TABLE_LOG2+1:2];
        uidx = bus.upd_pc[TABLE_LOG2+1:2];
`ifdef SYNC_QUEUE_TBC_TAG_EN
        pc_tag        = bus.pc[ADDR_SIZE-1:TABLE_LOG2+2];
        upd_tag       = bus.upd_pc[ADDR_SIZE-1:TABLE_LOG2+2];
        predict_taken = v[idx] && ctr[idx][1] && (tag[idx] == pc_tag);
        // A different branch claiming this slot restarts from weakly not-taken.
        upd_base      = (tag[uidx] == upd_tag) ? ctr[uidx] : 2'b01;
`else
        predict_taken = v[idx] && ctr[idx][1];
        upd_base      = ctr[uidx];
`endif
        if (bus.upd_taken) upd_ctr = (upd_base == 2'b11) ? 2'b11 : upd_base + 2'd1;
        else               upd_ctr = (upd_base == 2'b00) ? 2'b00 : upd_base - 2'd1;
        bus.next_pc    = predict_taken ? target[idx] : bus.pc + ADDR_SIZE'(4);
        unused_pc_bits = ^{bus.pc, bus.upd_pc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i]    <= 2'b01;
                target[i] <= '0;
`ifdef SYNC_QUEUE_TBC_TAG_EN
                tag[i]    <= '0;
`endif
            end
            v <= '0;
        end else if (bus.upd_valid) begin
            ctr[uidx] <= upd_ctr;
            if (bus.upd_taken) begin
                target[uidx] <= bus.upd_target;
                v[uidx]      <= 1'b1;
            end
`ifdef SYNC_QUEUE_TBC_TAG_EN
            tag[uidx] <= upd_tag;
`endif
        end
    end
endmodule

// File: tb/tb_sync_queue_two_bit_counter.sv
// Directed bench for sync_queue_two_bit_counter: FIFO reads are scored by a negedge monitor
// against a queue of expected entries; flags and predictor outputs are checked directly.
module tb_sync_queue_two_bit_counter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [95:0] exp_q [$];

    sync_queue_two_bit_counter_if #(.DATA_SIZE(96), .ADDR_SIZE(32)) bus ();

    sync_queue_two_bit_counter #(
        .DATA_SIZE(96), .QUEUE_SIZE(16), .ADDR_SIZE(32), .TABLE_LOG2(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wv, input logic [95:0] wd, input logic rr, input logic k);
        bus.wvalid = wv;
        bus.wdata  = wd;
        bus.rready = rr;
        bus.kill   = k;
    endtask

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic predUpdate(input logic [31:0] upc, input logic taken, input logic [31:0] tgt);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = upc;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
        tick();
        bus.upd_valid  = 1'b0;
    endtask

    // Scoreboard monitor: every accepted read must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.rvalid && bus.rready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_read: got 0x%0h, expected no data", bus.rdata);
            end else begin
                checkOutput("fifo_read", bus.rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the summary");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 96'h0, 1'b0, 1'b0);
        bus.pc         = 32'h100;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = 32'h0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = 32'h0;
        repeat (2) tick();
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_rvalid",      96'(bus.rvalid),      96'h0);
        checkOutput("reset_wready",      96'(bus.wready),      96'h1);
        checkOutput("reset_wready_next", 96'(bus.wready_next), 96'h1);
        checkOutput("reset_rdata",       bus.rdata,            96'h0);
        checkOutput("reset_next_pc",     96'(bus.next_pc),     96'h104);
        tick();

        // Three writes, first must not bypass to the read side in its own cycle
        applyStimulus(1'b1, 96'hA, 1'b0, 1'b0);
        exp_q.push_back(96'hA);
        @(negedge clk);
        checkOutput("no_bypass_rvalid", 96'(bus.rvalid), 96'h0);
        tick();
        applyStimulus(1'b1, 96'hB, 1'b0, 1'b0); exp_q.push_back(96'hB); tick();
        applyStimulus(1'b1, 96'hC, 1'b0, 1'b0); exp_q.push_back(96'hC); tick();
        applyStimulus(1'b0, 96'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("head_rvalid", 96'(bus.rvalid), 96'h1);
        checkOutput("head_rdata",  bus.rdata,       96'hA);
        tick();
        applyStimulus(1'b0, 96'h0, 1'b1, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b0, 96'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("empty_after_three_reads", 96'(bus.rvalid), 96'h1 ^ 96'h1);
        tick();

        // Fill to capacity, then try a dropped write and a dropped write-with-read
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 96'h100 + 96'(i), 1'b0, 1'b0);
            exp_q.push_back(96'h100 + 96'(i));
            tick();
        end
        applyStimulus(1'b1, 96'hDEAD, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full_wready",      96'(bus.wready),      96'h0);
        checkOutput("full_wready_next", 96'(bus.wready_next), 96'h0);
        checkOutput("full_rvalid",      96'(bus.rvalid),      96'h1);
        tick();
        applyStimulus(1'b1, 96'hBEEF, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("full_rw_wready_next", 96'(bus.wready_next), 96'h1);
        tick();

        // Count is now 15: next-cycle readiness depends on the same-cycle read
        applyStimulus(1'b0, 96'h0, 1'b0, 1'b0);
        #1 checkOutput("count15_wready", 96'(bus.wready), 96'h1);
        applyStimulus(1'b1, 96'h200, 1'b0, 1'b0);
        #1 checkOutput("count15_write_wready_next", 96'(bus.wready_next), 96'h0);
        applyStimulus(1'b1, 96'h200, 1'b1, 1'b0);
        exp_q.push_back(96'h200);
        #1 checkOutput("count15_rw_wready_next", 96'(bus.wready_next), 96'h1);
        tick();

        applyStimulus(1'b0, 96'h0, 1'b1, 1'b0);
        for (int n = 0; n < 40 && bus.rvalid; n++) tick();
        applyStimulus(1'b0, 96'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("drain_rvalid",       96'(bus.rvalid),     96'h0);
        checkOutput("scoreboard_drained", 96'(exp_q.size()),   96'h0);
        tick();

        // Kill with five entries queued and a concurrent write
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 96'h300 + 96'(i), 1'b0, 1'b0);
            exp_q.push_back(96'h300 + 96'(i));
            tick();
        end
        applyStimulus(1'b1, 96'h999, 1'b0, 1'b1);
        exp_q.delete();
        #1 checkOutput("kill_wready_next", 96'(bus.wready_next), 96'h1);
        tick();
        applyStimulus(1'b0, 96'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("kill_rvalid", 96'(bus.rvalid), 96'h0);
        checkOutput("kill_wready", 96'(bus.wready), 96'h1);
        checkOutput("kill_rdata",  bus.rdata,       96'h0);
        tick();
        applyStimulus(1'b1, 96'h400, 1'b0, 1'b0); exp_q.push_back(96'h400); tick();
        applyStimulus(1'b0, 96'h0, 1'b1, 1'b0); tick();
        applyStimulus(1'b0, 96'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post_kill_rvalid",    96'(bus.rvalid),   96'h0);
        checkOutput("post_kill_drained",   96'(exp_q.size()), 96'h0);
        tick();

        // Predictor training at 0x100 -> 0x200; lookup during update sees the old entry
        bus.pc         = 32'h100;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h100;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h200;
        @(negedge clk);
        checkOutput("lookup_during_update", 96'(bus.next_pc), 96'h104);
        tick();
        bus.upd_valid = 1'b0;
        predUpdate(32'h100, 1'b1, 32'h200);
        @(negedge clk);
        checkOutput("taken_twice", 96'(bus.next_pc), 96'h200);
        predUpdate(32'h100, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("not_taken_once", 96'(bus.next_pc), 96'h200);
        predUpdate(32'h100, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("not_taken_twice", 96'(bus.next_pc), 96'h104);
        predUpdate(32'h100, 1'b0, 32'h0);
        predUpdate(32'h100, 1'b1, 32'h200);
        @(negedge clk);
        checkOutput("floor_saturation", 96'(bus.next_pc), 96'h104);
        predUpdate(32'h100, 1'b1, 32'h200);
        predUpdate(32'h100, 1'b1, 32'h200);
        predUpdate(32'h100, 1'b1, 32'h200);
        predUpdate(32'h100, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("ceiling_saturation", 96'(bus.next_pc), 96'h200);

        bus.pc = 32'h200;
        @(negedge clk);
`ifdef SYNC_QUEUE_TBC_TAG_EN
        checkOutput("alias_lookup", 96'(bus.next_pc), 96'h204);
`else
        checkOutput("alias_lookup", 96'(bus.next_pc), 96'h200);
`endif
        bus.pc = 32'hFFFF_FFFC;
        @(negedge clk);
        checkOutput("pc_wrap", 96'(bus.next_pc), 96'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
